ddr_a2m_burst_seq: RTL

//  Per-beat address sequencer for the AXI-to-MBA bridge. Accepts one AXI address-channel command (addr/len/size/burst)
//  and emits one MBA beat per handshake, with the address computed for FIXED, INCR and WRAP bursts.

---
 rtl/ddr_a2m_burst_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ddr_a2m_burst_seq.sv
// Per-beat address sequencer for the AXI-to-MBA bridge: takes one AXI address command
// and walks FIXED/INCR/WRAP beat addresses, one beat per downstream handshake.
module ddr_a2m_burst_seq #(
    parameter int AW = 32,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [2:0]    cmd_size,
    input  logic [1:0]    cmd_burst,
    output logic          beat_valid,
    input  logic          beat_ready,
    output logic [AW-1:0] beat_addr,
    output logic [LW-1:0] beat_num,
    output logic          beat_last,
    output logic          cmd_err
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_t;

    state_t        state, state_next;
    mode_t         mode_q, cmd_mode;
    logic [LW-1:0] len_q;
    logic [2:0]    shift_q, cmd_shift;
    logic          cmd_bad;
    logic          cmd_fire, beat_fire, last_fire;

    logic [7:0]    size_mask;
    logic [AW-1:0] step, aligned, incr_addr, wrap_mask, wrap_addr, next_addr;

    assign beat_valid = (state == RUN);
    assign beat_fire  = beat_valid & beat_ready;
    assign last_fire  = beat_fire & beat_last;
    assign cmd_ready  = rst_n & ((state == IDLE) | last_fire);
    assign cmd_fire   = cmd_valid & cmd_ready;

    // Decode the offered command; illegal WRAP lengths and reserved bursts degrade to INCR.
    always_comb begin
        cmd_shift = 3'd0;
        cmd_mode  = MODE_INCR;
        cmd_bad   = 1'b0;
        if (cmd_size >= 3'd1 && cmd_size <= 3'd4) begin
            cmd_shift = cmd_size;
        end
        case (cmd_burst)
            2'd0: cmd_mode = MODE_FIXED;
            2'd1: cmd_mode = MODE_INCR;
            2'd2: begin
                if (cmd_len == LW'(1) || cmd_len == LW'(3) ||
                    cmd_len == LW'(7) || cmd_len == LW'(15)) begin
                    cmd_mode = MODE_WRAP;
                end else begin
                    cmd_bad = 1'b1;
                end
            end
            default: cmd_bad = 1'b1;
        endcase
    end

    // Only the low byte is masked for alignment: the largest step is 16 bytes.
    always_comb begin
        step      = AW'(1) << shift_q;
        size_mask = 8'hFF << shift_q;
        aligned   = {beat_addr[AW-1:8], beat_addr[7:0] & size_mask};
        incr_addr = aligned + step;
        wrap_mask = ((AW'(len_q) + AW'(1)) << shift_q) - AW'(1);
        wrap_addr = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
        case (mode_q)
            MODE_FIXED: next_addr = beat_addr;
            MODE_WRAP:  next_addr = wrap_addr;
            default:    next_addr = incr_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = RUN;
            RUN:     if (last_fire && !cmd_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_addr <= '0;
            beat_num  <= '0;
            beat_last <= 1'b0;
            cmd_err   <= 1'b0;
            len_q     <= '0;
            shift_q   <= 3'd0;
            mode_q    <= MODE_INCR;
        end else if (cmd_fire) begin
            beat_addr <= cmd_addr;
            beat_num  <= '0;
            beat_last <= (cmd_len == '0);
            cmd_err   <= cmd_bad;
            len_q     <= cmd_len;
            shift_q   <= cmd_shift;
            mode_q    <= cmd_mode;
        end else if (beat_fire && !beat_last) begin
            beat_addr <= next_addr;
            beat_num  <= beat_num + LW'(1);
            beat_last <= ((beat_num + LW'(1)) == len_q);
        end
    end

endmodule
